// File: rtl/cache_ram_responder_if.sv
//------------------------------------------------------------------------------
// Module  : cache_ram_responder_if
// Brief   : Cache <-> RAM responder request/response bundle. The cache drives
//           requests through the master modport; the RAM responder answers
//           through the slave modport.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface cache_ram_responder_if #(
   parameter int RAM_ADDRESS_BITS = 10,
   parameter int DATA_WIDTH       = 32,
   parameter int BLOCK_BITS       = 2
) ();
   logic                        req;
   logic [RAM_ADDRESS_BITS-1:0] address;
   logic [DATA_WIDTH-1:0]       write_data;
   logic                        write_en;
   logic                        ready;
   logic [DATA_WIDTH-1:0]       read_data;
   logic                        read_valid;
   logic [BLOCK_BITS-1:0]       read_offset;
   logic                        read_last;
   logic                        write_ack;

   modport master (
      output req, address, write_data, write_en,
      input  ready, read_data, read_valid, read_offset, read_last, write_ack
   );

   modport slave (
      input  req, address, write_data, write_en,
      output ready, read_data, read_valid, read_offset, read_last, write_ack
   );
endinterface

`default_nettype wire

// File: rtl/cache_ram_responder.sv
//------------------------------------------------------------------------------
// Module  : cache_ram_responder
// Brief   : Backing-memory responder for cache misses and write-throughs.
//           One request at a time; fixed access latency; read misses return
//           a whole block as a contiguous burst, writes return a one-cycle ack.
//           Optional build macro CRITICAL_WORD_FIRST_EN starts each burst at
//           the requested word instead of offset 0.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cache_ram_responder #(
   parameter int RAM_ADDRESS_BITS = 10,
   parameter int DATA_WIDTH       = 32,
   parameter int BLOCK_BITS       = 2,
   parameter int LATENCY          = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   cache_ram_responder_if.slave  bus
);

   localparam int c_depth = 2 ** RAM_ADDRESS_BITS;
   localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [BLOCK_BITS-1:0] c_last_beat = '1;

   // Parameter sanity: latency must be at least one cycle and a block must be
   // strictly smaller than the memory.
   if (LATENCY < 1 || BLOCK_BITS >= RAM_ADDRESS_BITS) begin : g_bad_params
      $error("cache_ram_responder: need LATENCY >= 1 and BLOCK_BITS < RAM_ADDRESS_BITS");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_WACK  = 2'd3
   } state_t;

   state_t                      r_state;
   logic [c_cnt_w-1:0]          r_cnt;
   logic [RAM_ADDRESS_BITS-1:0] r_addr;
   logic [DATA_WIDTH-1:0]       r_wdata;
   logic                        r_we;
   logic [BLOCK_BITS-1:0]       r_beat;
   logic [DATA_WIDTH-1:0]       r_mem [0:c_depth-1];

   logic [BLOCK_BITS-1:0]       w_start;
   logic [BLOCK_BITS-1:0]       w_offset;
   logic [RAM_ADDRESS_BITS-1:0] w_rd_addr;
   logic                        w_commit;

`ifdef CRITICAL_WORD_FIRST_EN
   assign w_start = r_addr[BLOCK_BITS-1:0];
`else
   assign w_start = '0;
`endif

   // Offset wraps modulo the block size; it never carries into the block base.
   assign w_offset  = w_start + r_beat;
   assign w_rd_addr = {r_addr[RAM_ADDRESS_BITS-1:BLOCK_BITS], w_offset};
   assign w_commit  = (r_state == S_WAIT) && (r_cnt == '0) && r_we;

   // Memory write port; contents survive reset, and a reset at the commit
   // edge cancels the write.
   always_ff @(posedge clk) begin
      if (reset_n && w_commit) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   // Request FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_we           <= 1'b0;
         r_beat         <= '0;
         bus.ready      <= 1'b1;
         bus.read_valid <= 1'b0;
         bus.read_data  <= '0;
         bus.read_offset<= '0;
         bus.read_last  <= 1'b0;
         bus.write_ack  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req && bus.ready) begin
                  r_addr    <= bus.address;
                  r_wdata   <= bus.write_data;
                  r_we      <= bus.write_en;
                  r_beat    <= '0;
                  r_cnt     <= c_cnt_w'(LATENCY - 1);
                  r_state   <= S_WAIT;
                  bus.ready <= 1'b0;
               end
            end
            S_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_we) begin
                  r_state       <= S_WACK;
                  bus.write_ack <= 1'b1;
               end else begin
                  r_state         <= S_BURST;
                  bus.read_valid  <= 1'b1;
                  bus.read_data   <= r_mem[w_rd_addr];
                  bus.read_offset <= w_offset;
                  bus.read_last   <= (r_beat == c_last_beat);
                  r_beat          <= r_beat + 1'b1;
               end
            end
            S_BURST: begin
               if (bus.read_last) begin
                  r_state         <= S_IDLE;
                  bus.ready       <= 1'b1;
                  bus.read_valid  <= 1'b0;
                  bus.read_data   <= '0;
                  bus.read_offset <= '0;
                  bus.read_last   <= 1'b0;
               end else begin
                  bus.read_data   <= r_mem[w_rd_addr];
                  bus.read_offset <= w_offset;
                  bus.read_last   <= (r_beat == c_last_beat);
                  r_beat          <= r_beat + 1'b1;
               end
            end
            S_WACK: begin
               r_state       <= S_IDLE;
               bus.write_ack <= 1'b0;
               bus.ready     <= 1'b1;
            end
            default: begin
               r_state   <= S_IDLE;
               bus.ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_ram_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_cache_ram_responder
// Brief   : Scoreboard bench for cache_ram_responder. Expected acks and beats
//           (with their cycle stamps) are queued as requests are accepted and
//           matched against observed responses in order.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cache_ram_responder;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int BB    = 2;
   localparam int LAT   = 3;
   localparam int BEATS = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cache_ram_responder_if #(.RAM_ADDRESS_BITS(AW), .DATA_WIDTH(DW), .BLOCK_BITS(BB)) bus ();

   cache_ram_responder #(
      .RAM_ADDRESS_BITS(AW), .DATA_WIDTH(DW), .BLOCK_BITS(BB), .LATENCY(LAT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct packed {
      logic          wr;
      logic [DW-1:0] data;
      logic [BB-1:0] off;
      logic          last;
      logic [31:0]   cyc;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         obs_q[$];
   logic [DW-1:0] model [0:2**AW-1];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          viol = 0;

   // Edge counter: at a negedge, cyc equals the number of posedges so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: records every beat/ack with its cycle stamp.
   always @(negedge clk) begin
      if (cyc >= 2) begin
         if (bus.read_valid === 1'b1)
            obs_q.push_back('{wr: 1'b0, data: bus.read_data, off: bus.read_offset,
                              last: bus.read_last, cyc: cyc});
         else if (bus.read_data !== '0 || bus.read_last !== 1'b0)
            viol = viol + 1;
         if (bus.write_ack === 1'b1)
            obs_q.push_back('{wr: 1'b1, data: '0, off: '0, last: 1'b0, cyc: cyc});
      end
   end

   initial begin
      for (int i = 0; i < 2**AW; i++) model[i] = '0;
      bus.req = 1'b0; bus.write_en = 1'b0; bus.address = '0; bus.write_data = '0;
   end

   function automatic string pair_str(bit ok, ev_t o, ev_t e);
      return $sformatf("got ok=%0d wr=%0d data=%h off=%0d last=%0d cyc=%0d, want wr=%0d data=%h off=%0d last=%0d cyc=%0d",
                       ok, o.wr, o.data, o.off, o.last, o.cyc, e.wr, e.data, e.off, e.last, e.cyc);
   endfunction

   // Drive a request at a negedge and hold it until accepted; queue the
   // expected responses. Returns the acceptance edge number.
   task automatic issue(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output int unsigned k);
      int n;
      logic [BB-1:0] start;
      logic [BB-1:0] off;
      n = 0;
      bus.req = 1'b1; bus.write_en = we; bus.address = addr; bus.write_data = data;
      while (bus.ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL issue_timeout: ready stayed %b, want 1", bus.ready);
      end
      k = cyc + 1;
      if (we) begin
         model[addr] = data;
         exp_q.push_back('{wr: 1'b1, data: '0, off: '0, last: 1'b0, cyc: k + LAT});
      end else begin
`ifdef CRITICAL_WORD_FIRST_EN
         start = addr[BB-1:0];
`else
         start = '0;
`endif
         for (int i = 0; i < BEATS; i++) begin
            off = start + BB'(i);
            exp_q.push_back('{wr: 1'b0, data: model[{addr[AW-1:BB], off}], off: off,
                              last: (i == BEATS - 1), cyc: k + LAT + i});
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_cyc(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   // Pop the next expected event and the next observed one (bounded wait).
   task automatic get_pair(output ev_t e, output ev_t o, output bit ok);
      int n;
      n = 0; ok = 1'b0; e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      while (obs_q.size() == 0 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      int unsigned k;
      ev_t e, o; bit ok;
      reset_n = 1'b0;
      bus.req = 1'b1; bus.write_en = 1'b1; bus.address = 10'h020; bus.write_data = 32'hA5A50020;
      repeat (2) @(negedge clk);
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.ready); end
      checks++; if (bus.read_valid !== 1'b0) begin errors++; $display("FAIL rst_read_valid: got %b want 0", bus.read_valid); end
      checks++; if (bus.read_data !== '0) begin errors++; $display("FAIL rst_read_data: got %h want 0", bus.read_data); end
      checks++; if (bus.read_offset !== '0) begin errors++; $display("FAIL rst_read_offset: got %0d want 0", bus.read_offset); end
      checks++; if (bus.read_last !== 1'b0) begin errors++; $display("FAIL rst_read_last: got %b want 0", bus.read_last); end
      checks++; if (bus.write_ack !== 1'b0) begin errors++; $display("FAIL rst_write_ack: got %b want 0", bus.write_ack); end
      reset_n = 1'b1;
      issue(1'b1, 10'h020, 32'hA5A50020, k);
      bus.req = 1'b0;
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_accept_after_release: ready got %b want 0", bus.ready); end
      get_pair(e, o, ok);
      checks++; if (!ok || o !== e) begin errors++; $display("FAIL rst_first_write: %s", pair_str(ok, o, e)); end
   endtask

   task automatic test_write();
      int unsigned k;
      ev_t e, o; bit ok;
      issue(1'b1, 10'h3A5, 32'hDEADBEEF, k);
      bus.req = 1'b0;
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL wr_ready_k1: got %b want 0", bus.ready); end
      wait_cyc(k + LAT);
      checks++; if (bus.write_ack !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL wr_ack_cycle: ack=%b ready=%b want ack=1 ready=0", bus.write_ack, bus.ready); end
      wait_cyc(k + LAT + 1);
      checks++; if (bus.write_ack !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL wr_after_ack: ack=%b ready=%b want ack=0 ready=1", bus.write_ack, bus.ready); end
      get_pair(e, o, ok);
      checks++; if (!ok || o !== e) begin errors++; $display("FAIL wr_ack_event: %s", pair_str(ok, o, e)); end
      issue(1'b0, 10'h3A4, '0, k);
      bus.req = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         get_pair(e, o, ok);
         checks++; if (!ok || o !== e) begin errors++; $display("FAIL wr_readback[%0d]: %s", i, pair_str(ok, o, e)); end
      end
   endtask

   task automatic test_burst_order();
      int unsigned k;
      ev_t e, o; bit ok;
      logic [DW-1:0] vals [4];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 10'h3A4 + 10'(i), vals[i], k);
         bus.req = 1'b0;
      end
      issue(1'b0, 10'h3A6, '0, k);
      bus.req = 1'b0;
      for (int i = 0; i < 4 + BEATS; i++) begin
         get_pair(e, o, ok);
         checks++; if (!ok || o !== e) begin errors++; $display("FAIL burst_order[%0d]: %s", i, pair_str(ok, o, e)); end
      end
   endtask

   task automatic test_ignore_busy();
      int unsigned k;
      ev_t e, o; bit ok;
      issue(1'b1, 10'h010, 32'h0BAD0010, k);
      bus.req = 1'b0;
      issue(1'b0, 10'h3A4, '0, k);
      bus.req = 1'b0;
      wait_cyc(k + LAT + 1);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", bus.ready); end
      bus.req = 1'b1; bus.write_en = 1'b1; bus.address = 10'h010; bus.write_data = 32'hFFFFFFFF;
      @(negedge clk);
      bus.req = 1'b0;
      for (int i = 0; i < 1 + BEATS; i++) begin
         get_pair(e, o, ok);
         checks++; if (!ok || o !== e) begin errors++; $display("FAIL busy_burst[%0d]: %s", i, pair_str(ok, o, e)); end
      end
      repeat (LAT + 3) @(negedge clk);
      #1;
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL busy_spurious: %0d extra events, want 0", obs_q.size()); obs_q.delete(); end
      issue(1'b0, 10'h010, '0, k);
      bus.req = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         get_pair(e, o, ok);
         checks++; if (!ok || o !== e) begin errors++; $display("FAIL busy_readback[%0d]: %s", i, pair_str(ok, o, e)); end
      end
   endtask

   task automatic test_reset_mid();
      int unsigned k;
      ev_t e, o; bit ok;
      logic [DW-1:0] old;
      issue(1'b0, 10'h3A4, '0, k);
      bus.req = 1'b0;
      wait_cyc(k + LAT + 2);
      reset_n = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      checks++; if (bus.read_valid !== 1'b0 || bus.read_last !== 1'b0 || bus.ready !== 1'b1) begin
         errors++; $display("FAIL midrst_outputs: valid=%b last=%b ready=%b want 0 0 1", bus.read_valid, bus.read_last, bus.ready);
      end
      reset_n = 1'b1;
      for (int i = 0; i < BEATS - 1; i++) begin
         get_pair(e, o, ok);
         checks++; if (!ok || o !== e) begin errors++; $display("FAIL midrst_beats[%0d]: %s", i, pair_str(ok, o, e)); end
      end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_extra: %0d extra events, want 0", obs_q.size()); obs_q.delete(); end
      old = model[10'h3A7];
      issue(1'b1, 10'h3A7, 32'h77777777, k);
      bus.req = 1'b0;
      model[10'h3A7] = old;
      void'(exp_q.pop_back());
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      #1;
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_write_ack: %0d events, want 0", obs_q.size()); obs_q.delete(); end
      issue(1'b0, 10'h3A4, '0, k);
      bus.req = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         get_pair(e, o, ok);
         checks++; if (!ok || o !== e) begin errors++; $display("FAIL midrst_readback[%0d]: %s", i, pair_str(ok, o, e)); end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned k;
      int unsigned want_k;
      ev_t e, o; bit ok;
      logic          wes   [6];
      logic [AW-1:0] addrs [6];
      logic [DW-1:0] datas [6];
      wes[0] = 1'b1; addrs[0] = 10'h100; datas[0] = 32'hC0FFEE01;
      wes[1] = 1'b0; addrs[1] = 10'h100; datas[1] = '0;
      wes[2] = 1'b1; addrs[2] = 10'h105; datas[2] = 32'hC0FFEE05;
      wes[3] = 1'b0; addrs[3] = 10'h104; datas[3] = '0;
      wes[4] = 1'b1; addrs[4] = 10'h202; datas[4] = 32'h5EED0202;
      wes[5] = 1'b0; addrs[5] = 10'h201; datas[5] = '0;
      want_k = 0;
      for (int i = 0; i < 6; i++) begin
         issue(wes[i], addrs[i], datas[i], k);
         if (i > 0) begin
            checks++; if (k !== want_k) begin errors++; $display("FAIL b2b_accept_edge[%0d]: got %0d want %0d", i, k, want_k); end
         end
         want_k = wes[i] ? k + LAT + 2 : k + LAT + BEATS + 1;
      end
      bus.req = 1'b0;
      for (int i = 0; i < 3 + 3 * BEATS; i++) begin
         get_pair(e, o, ok);
         checks++; if (!ok || o !== e) begin errors++; $display("FAIL b2b_order[%0d]: %s", i, pair_str(ok, o, e)); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_burst_order();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      checks++; if (viol !== 0) begin errors++; $display("FAIL idle_outputs: %0d cycles with data/last while not valid, want 0", viol); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/cache_ram_responder.md
Name: cache_ram_responder

Overview:
RAM-side responder for the cache's miss/propagation interface. It accepts one request at a time from the cache: either a single-word write-through, or a read miss that returns a whole cache block as a burst. It models backing memory with a fixed access latency. It sits between the cache and the board RAM and serves as both the synthesizable memory stub and the verification reference for cache refill traffic.

Parameters:
RAM_ADDRESS_BITS, 10, word-address width; memory depth = 2**RAM_ADDRESS_BITS words
DATA_WIDTH, 32, word width
BLOCK_BITS, 2, log2 of words per cache block; BEATS = 2**BLOCK_BITS
LATENCY, 3, cycles from request acceptance to first response; must be >= 1

Ports:
clk  in  1  clock; all logic on posedge
reset_n  in  1  reset, synchronous, active-low
req  in  1  request strobe; accepted on a posedge when req && ready
address  in  RAM_ADDRESS_BITS  request word address
write_data  in  DATA_WIDTH  write word (used when write_en=1)
write_en  in  1  1 = write request, 0 = block read request
ready  out  1  1 only in IDLE; request may be accepted
read_data  out  DATA_WIDTH  burst beat data; 0 when read_valid=0
read_valid  out  1  beat valid; no backpressure
read_offset  out  BLOCK_BITS  block offset of the current beat
read_last  out  1  high with the final beat of a burst
write_ack  out  1  one-cycle pulse when a write commits

Behaviour:
- Reset (reset_n=0 at a posedge): state=IDLE, ready=1, read_valid=0, read_data=0, read_offset=0, read_last=0, write_ack=0, latency counter=0. Memory contents are not cleared by reset. Memory is all-zero at time 0.
- All outputs are registered.
- Acceptance: at the posedge k where req && ready, latch address, write_data and write_en into internal registers. State becomes WAIT and ready=0 from cycle k+1.
- req while ready=0 is ignored. It is not queued.
- WAIT lasts exactly LATENCY cycles, counted by a down-counter loaded with LATENCY-1.
- Read path:
  - At edge k+LATENCY, state becomes BURST.
  - Beat i (i = 0..BEATS-1) is presented in the cycle after edge k+LATENCY+i.
  - read_data = mem[{address[RAM_ADDRESS_BITS-1:BLOCK_BITS], offset_i}] and read_offset = offset_i.
  - Base ordering: offset_i = i.
  - read_last=1 only on beat BEATS-1.
  - At edge k+LATENCY+BEATS, state becomes IDLE with ready=1 and read_valid=0.
  - Beats are contiguous; none are skipped or stalled.
- Write path:
  - At edge k+LATENCY, mem[address] <= write_data and state becomes WACK.
  - write_ack=1 for that one cycle.
  - At the next edge, state becomes IDLE with ready=1.
  - Only the addressed word is written; the rest of the block is untouched.
- Back-to-back: req held high is accepted again on the first edge where ready=1. There are no dead cycles beyond the IDLE cycle.
- Reset mid-operation: the operation is aborted immediately and outputs return to their reset values.
  - A write reset before its commit edge is not committed.
  - A burst cut short does not produce read_last.
- Address wrap: offset arithmetic is modulo BEATS and never carries into the block base.
- Elaboration check: $error if LATENCY < 1 or BLOCK_BITS >= RAM_ADDRESS_BITS.
- FSM states: IDLE -> WAIT -> BURST -> IDLE for reads; IDLE -> WAIT -> WACK -> IDLE for writes.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: the burst starts at the requested word: offset_i = (address[BLOCK_BITS-1:0] + i) mod BEATS. read_last is still asserted on the BEATS-th beat.
- Undefined: offset_i = i, i.e. beats always start at offset 0. Latency, beat count and all other timing are identical in both builds.

Test Plan:
1. Hold reset_n=0 for 2 cycles with req=1 -> all outputs 0, ready=1. The request is not accepted until reset_n=1.
2. LATENCY=3. Write 0x3A5 with data 0xDEADBEEF, accepted at edge k -> ready=0 from k+1; write_ack high only in the cycle after edge k+3; ready=1 after edge k+4. A later read of block 0x3A4 shows beat offset 1 = 0xDEADBEEF.
3. Write 0x3A4..0x3A7 with 0x11, 0x22, 0x33, 0x44, then read 0x3A6:
   - Without the macro: offsets 0, 1, 2, 3 with data 0x11, 0x22, 0x33, 0x44; read_last on beat 4; first beat 3 cycles after acceptance.
   - With CRITICAL_WORD_FIRST_EN: offsets 2, 3, 0, 1 with data 0x33, 0x44, 0x11, 0x22.
4. Pulse req with write_en=1 to address 0x010 during a read burst -> ignored. mem[0x010] is unchanged and there is no write_ack.
5. Assert reset_n=0 during beat 2 of a burst -> read_valid=0 next cycle, no read_last, ready=1. A write reset during WAIT leaves the target word at its old value.
6. Hold req=1 continuously with alternating write/read -> each request is accepted on the first edge with ready=1, and the response order matches the request order.
